// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate strobe, free-running h/v counters,
// active-low syncs, visible-area flag and line/frame strobes, all registered.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam logic [3:0]  L_DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [9:0]  L_H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  L_V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  L_H_SYNC  = 10'(H_SYNC);
  localparam logic [9:0]  L_V_SYNC  = 10'(V_SYNC);
  // Window bounds are 11 bits so an active area ending at 1024 still compares correctly.
  localparam logic [10:0] L_H_ON    = 11'(H_SYNC + H_BP);
  localparam logic [10:0] L_H_OFF   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] L_V_ON    = 11'(V_SYNC + V_BP);
  localparam logic [10:0] L_V_OFF   = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic        L_PIX_RST = (CLK_DIV == 1) ? 1'b1 : 1'b0;

  logic [3:0] r_div_cnt;
  logic [3:0] w_div_next;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_pix_en;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       r_pix_en;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_bright;
  logic       r_line_tick;
  logic       r_frame_tick;

  // Next-state divider and raster counters; counters only move on a pixel strobe.
  always_comb begin
    w_pix_en = (r_div_cnt == L_DIV_MAX);
    w_h_wrap = (r_h_cnt == L_H_MAX);
    w_v_wrap = (r_v_cnt == L_V_MAX);
    w_h_next = r_h_cnt;
    w_v_next = r_v_cnt;
    if (w_pix_en) begin
      w_div_next = 4'd0;
      if (w_h_wrap) begin
        w_h_next = 10'd0;
        if (w_v_wrap) begin
          w_v_next = 10'd0;
        end else begin
          w_v_next = r_v_cnt + 10'd1;
        end
      end else begin
        w_h_next = r_h_cnt + 10'd1;
      end
    end else begin
      w_div_next = r_div_cnt + 4'd1;
    end
  end

  // State and derived outputs, decoded from next-state counters for zero skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt    <= 4'd0;
      r_h_cnt      <= 10'd0;
      r_v_cnt      <= 10'd0;
      r_pix_en     <= L_PIX_RST;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_bright     <= 1'b0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_div_cnt    <= w_div_next;
      r_h_cnt      <= w_h_next;
      r_v_cnt      <= w_v_next;
      r_pix_en     <= (w_div_next == L_DIV_MAX);
      r_hsync      <= (w_h_next >= L_H_SYNC);
      r_vsync      <= (w_v_next >= L_V_SYNC);
      r_bright     <= ({1'b0, w_h_next} >= L_H_ON) && ({1'b0, w_h_next} < L_H_OFF) &&
                      ({1'b0, w_v_next} >= L_V_ON) && ({1'b0, w_v_next} < L_V_OFF);
      r_line_tick  <= w_pix_en & w_h_wrap;
      r_frame_tick <= w_pix_en & w_h_wrap & w_v_wrap;
    end
  end

  assign pix_en     = r_pix_en;
  assign hCount     = r_h_cnt;
  assign vCount     = r_v_cnt;
  assign hSync      = r_hsync;
  assign vSync      = r_vsync;
  assign bright     = r_bright;
  assign line_tick  = r_line_tick;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing (instance A) plus two shrunken rasters
// (B: CLK_DIV=1, C: CLK_DIV=3; 16x12 lines) so frame-level behaviour fits a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  logic       a_pix, a_hs, a_vs, a_br, a_lt, a_ft;
  logic [9:0] a_h, a_v;
  logic       b_pix, b_hs, b_vs, b_br, b_lt, b_ft;
  logic [9:0] b_h, b_v;
  logic       c_pix, c_hs, c_vs, c_br, c_lt, c_ft;
  logic [9:0] c_h, c_v;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .pix_en(a_pix), .hCount(a_h), .vCount(a_v),
    .hSync(a_hs), .vSync(a_vs), .bright(a_br), .line_tick(a_lt), .frame_tick(a_ft)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(3), .H_BP(2), .H_ACTIVE(8), .H_TOTAL(16),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(6), .V_TOTAL(12)
  ) u_b (
    .clk(clk), .rst(rst), .pix_en(b_pix), .hCount(b_h), .vCount(b_v),
    .hSync(b_hs), .vSync(b_vs), .bright(b_br), .line_tick(b_lt), .frame_tick(b_ft)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_SYNC(3), .H_BP(2), .H_ACTIVE(8), .H_TOTAL(16),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(6), .V_TOTAL(12)
  ) u_c (
    .clk(clk), .rst(rst), .pix_en(c_pix), .hCount(c_h), .vCount(c_v),
    .hSync(c_hs), .vSync(c_vs), .bright(c_br), .line_tick(c_lt), .frame_tick(c_ft)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({a_pix, a_hs, a_vs, a_br, a_lt, a_ft} !== 6'b000000) begin
      fails++;
      $display("FAIL reset_flags_A got=%b exp=000000", {a_pix, a_hs, a_vs, a_br, a_lt, a_ft});
    end
    tests++;
    if ({a_h, a_v} !== 20'd0) begin
      fails++;
      $display("FAIL reset_counters_A got h=%0d v=%0d exp 0,0", a_h, a_v);
    end
    tests++;
    if ({b_pix, b_hs, b_vs, b_br, b_lt, b_ft} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_flags_B got=%b exp=100000", {b_pix, b_hs, b_vs, b_br, b_lt, b_ft});
    end
    tests++;
    if (c_pix !== 1'b0) begin
      fails++;
      $display("FAIL reset_pix_C got=%b exp=0", c_pix);
    end
  endtask

  task automatic test_power_up();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) tick();
      tests++;
      if (a_pix !== ((c % 4) == 3)) begin
        fails++;
        $display("FAIL pwr_pix_A cyc=%0d got=%b exp=%b", c, a_pix, ((c % 4) == 3));
      end
      tests++;
      if (a_h !== 10'(c / 4)) begin
        fails++;
        $display("FAIL pwr_hcount_A cyc=%0d got=%0d exp=%0d", c, a_h, c / 4);
      end
      tests++;
      if ({c_pix, c_h} !== {((c % 3) == 2), 10'(c / 3)}) begin
        fails++;
        $display("FAIL pwr_C cyc=%0d got pix=%b h=%0d exp pix=%b h=%0d",
                 c, c_pix, c_h, ((c % 3) == 2), c / 3);
      end
    end
  endtask

  task automatic test_line_wrap();
    int bad = 0;
    int eh, ev;
    logic elt, ehs, evs, epx;
    do_reset();
    for (int c = 0; c <= 6401; c++) begin
      if (c > 0) tick();
      eh  = (c / 4) % 800;
      ev  = c / 3200;
      elt = (c > 0) && ((c % 3200) == 0);
      ehs = (eh >= 96);
      evs = (ev >= 2);
      epx = ((c % 4) == 3);
      if (a_h !== 10'(eh) || a_v !== 10'(ev) || a_lt !== elt || a_ft !== 1'b0 ||
          a_hs !== ehs || a_vs !== evs || a_br !== 1'b0 || a_pix !== epx) begin
        if (bad == 0)
          $display("FAIL line_model_A cyc=%0d got h=%0d v=%0d lt=%b ft=%b hs=%b vs=%b br=%b pix=%b exp h=%0d v=%0d lt=%b ft=0 hs=%b vs=%b br=0 pix=%b",
                   c, a_h, a_v, a_lt, a_ft, a_hs, a_vs, a_br, a_pix, eh, ev, elt, ehs, evs, epx);
        bad++;
      end
      if (c == 383 || c == 384) begin
        tests++;
        if ({a_h, a_hs} !== {10'(c / 4), (c == 384)}) begin
          fails++;
          $display("FAIL hsync_edge cyc=%0d got h=%0d hs=%b exp h=%0d hs=%b", c, a_h, a_hs, c / 4, (c == 384));
        end
      end
      if (c == 3199) begin
        tests++;
        if ({a_h, a_v, a_lt} !== {10'd799, 10'd0, 1'b0}) begin
          fails++;
          $display("FAIL pre_wrap got h=%0d v=%0d lt=%b exp 799,0,0", a_h, a_v, a_lt);
        end
      end
      if (c == 3200) begin
        tests++;
        if ({a_h, a_v, a_lt, a_ft} !== {10'd0, 10'd1, 1'b1, 1'b0}) begin
          fails++;
          $display("FAIL line_wrap got h=%0d v=%0d lt=%b ft=%b exp 0,1,1,0", a_h, a_v, a_lt, a_ft);
        end
      end
      if (c == 3201) begin
        tests++;
        if (a_lt !== 1'b0) begin
          fails++;
          $display("FAIL line_tick_width got=%b exp=0", a_lt);
        end
      end
    end
    tests++;
    if (bad != 0) fails++;
  endtask

  task automatic test_frame_wrap();
    int bad_b = 0;
    int bad_c = 0;
    int hb, vb, hc, vc;
    logic eb_lt, eb_ft, ec_lt, ec_ft, ec_br, eb_br;
    do_reset();
    for (int c = 0; c <= 1200; c++) begin
      if (c > 0) tick();
      hb = c % 16;         vb = (c / 16) % 12;
      hc = (c / 3) % 16;   vc = (c / 48) % 12;
      eb_lt = (c > 0) && ((c % 16) == 0);
      eb_ft = (c > 0) && ((c % 192) == 0);
      ec_lt = (c > 0) && ((c % 48) == 0);
      ec_ft = (c > 0) && ((c % 576) == 0);
      eb_br = (hb >= 5) && (hb <= 12) && (vb >= 4) && (vb <= 9);
      ec_br = (hc >= 5) && (hc <= 12) && (vc >= 4) && (vc <= 9);
      if (b_pix !== 1'b1 || b_h !== 10'(hb) || b_v !== 10'(vb) || b_lt !== eb_lt ||
          b_ft !== eb_ft || b_hs !== (hb >= 3) || b_vs !== (vb >= 2) || b_br !== eb_br) begin
        if (bad_b == 0)
          $display("FAIL frame_model_B cyc=%0d got h=%0d v=%0d lt=%b ft=%b br=%b pix=%b exp h=%0d v=%0d lt=%b ft=%b br=%b pix=1",
                   c, b_h, b_v, b_lt, b_ft, b_br, b_pix, hb, vb, eb_lt, eb_ft, eb_br);
        bad_b++;
      end
      if (c_pix !== ((c % 3) == 2) || c_h !== 10'(hc) || c_v !== 10'(vc) || c_lt !== ec_lt ||
          c_ft !== ec_ft || c_hs !== (hc >= 3) || c_vs !== (vc >= 2) || c_br !== ec_br) begin
        if (bad_c == 0)
          $display("FAIL frame_model_C cyc=%0d got h=%0d v=%0d lt=%b ft=%b br=%b exp h=%0d v=%0d lt=%b ft=%b br=%b",
                   c, c_h, c_v, c_lt, c_ft, c_br, hc, vc, ec_lt, ec_ft, ec_br);
        bad_c++;
      end
      if (c == 95 || c == 96) begin
        tests++;
        if ({c_v, c_vs} !== {10'(c / 48), (c == 96)}) begin
          fails++;
          $display("FAIL vsync_edge_C cyc=%0d got v=%0d vs=%b exp v=%0d vs=%b", c, c_v, c_vs, c / 48, (c == 96));
        end
      end
      if (c == 575) begin
        tests++;
        if ({c_h, c_v, c_ft} !== {10'd15, 10'd11, 1'b0}) begin
          fails++;
          $display("FAIL pre_frame_C got h=%0d v=%0d ft=%b exp 15,11,0", c_h, c_v, c_ft);
        end
      end
      if (c == 576 || c == 1152) begin
        tests++;
        if ({c_h, c_v, c_lt, c_ft, c_vs} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0}) begin
          fails++;
          $display("FAIL frame_wrap_C cyc=%0d got h=%0d v=%0d lt=%b ft=%b vs=%b exp 0,0,1,1,0",
                   c, c_h, c_v, c_lt, c_ft, c_vs);
        end
      end
      if (c == 577) begin
        tests++;
        if ({c_lt, c_ft} !== 2'b00) begin
          fails++;
          $display("FAIL frame_tick_width_C got lt=%b ft=%b exp 0,0", c_lt, c_ft);
        end
      end
      if (c == 192) begin
        tests++;
        if ({b_h, b_v, b_lt, b_ft} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
          fails++;
          $display("FAIL frame_wrap_B got h=%0d v=%0d lt=%b ft=%b exp 0,0,1,1", b_h, b_v, b_lt, b_ft);
        end
      end
    end
    tests++;
    if (bad_b != 0) fails++;
    tests++;
    if (bad_c != 0) fails++;
  endtask

  task automatic test_bright();
    int   cc [12] = '{165, 204, 206, 207, 213, 228, 230, 231, 453, 455, 501, 502};
    logic ce [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int   bc [4]  = '{68, 69, 76, 77};
    logic be [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c <= 502; c++) begin
      if (c > 0) tick();
      for (int k = 0; k < 12; k++) begin
        if (c == cc[k]) begin
          tests++;
          if (c_br !== ce[k]) begin
            fails++;
            $display("FAIL bright_C cyc=%0d h=%0d v=%0d got=%b exp=%b", c, c_h, c_v, c_br, ce[k]);
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (c == bc[k]) begin
          tests++;
          if (b_br !== be[k]) begin
            fails++;
            $display("FAIL bright_B cyc=%0d h=%0d v=%0d got=%b exp=%b", c, b_h, b_v, b_br, be[k]);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    do_reset();
    while (cyc < 300) tick();
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({c_h, c_v, c_pix, c_hs, c_vs, c_br, c_lt, c_ft} !== 26'd0) begin
      fails++;
      $display("FAIL mid_reset_C got h=%0d v=%0d flags=%b exp 0,0,000000",
               c_h, c_v, {c_pix, c_hs, c_vs, c_br, c_lt, c_ft});
    end
    tests++;
    if ({a_h, a_v, a_pix, a_hs, a_vs, a_br, a_lt, a_ft} !== 26'd0) begin
      fails++;
      $display("FAIL mid_reset_A got h=%0d v=%0d flags=%b exp 0,0,000000",
               a_h, a_v, {a_pix, a_hs, a_vs, a_br, a_lt, a_ft});
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c <= 600; c++) begin
      if (c > 0) tick();
      if (c_ft !== (c == 576) || c_lt !== ((c > 0) && ((c % 48) == 0))) begin
        if (bad == 0)
          $display("FAIL post_reset_ticks_C cyc=%0d got lt=%b ft=%b exp lt=%b ft=%b",
                   c, c_lt, c_ft, ((c > 0) && ((c % 48) == 0)), (c == 576));
        bad++;
      end
      if (c == 2 || c == 3) begin
        tests++;
        if ({c_pix, c_h} !== {(c == 2), 10'(c / 3)}) begin
          fails++;
          $display("FAIL post_reset_pwr_C cyc=%0d got pix=%b h=%0d exp pix=%b h=%0d",
                   c, c_pix, c_h, (c == 2), c / 3);
        end
      end
    end
    tests++;
    if (bad != 0) fails++;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_line_wrap();
    test_frame_wrap();
    test_bright();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock: a pixel-rate enable, free-running horizontal/vertical counters, active-low sync pulses, the `bright` display-area flag, and line/frame strobes. It drives the pixel-colour side of the display path. Colour logic samples `hCount`, `vCount` and `bright`, and uses `frame_tick` to pace object motion. The visible area spans hCount 144..783 and vCount 35..514.

## Interface
- `CLK_DIV`, 4: clk cycles per pixel; 1..16.
- `H_SYNC`, 96: hSync low width, pixels.
- `H_BP`, 48: horizontal back porch, pixels.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_TOTAL`, 800: pixels per line; ≤1024.
- `V_SYNC`, 2: vSync low width, lines.
- `V_BP`, 33: vertical back porch, lines.
- `V_ACTIVE`, 480: visible lines.
- `V_TOTAL`, 525: lines per frame; ≤1024.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `pix_en`  out  1  one-clk pixel strobe, every CLK_DIV clks.
- `hCount`  out  10  horizontal position, 0..H_TOTAL-1.
- `vCount`  out  10  vertical position, 0..V_TOTAL-1.
- `hSync`  out  1  active-low horizontal sync.
- `vSync`  out  1  active-low vertical sync.
- `bright`  out  1  high inside the visible area.
- `line_tick`  out  1  one-clk pulse after hCount wraps.
- `frame_tick`  out  1  one-clk pulse after the frame wraps.

## Operation
- Divider `div_cnt` (4 bit) counts 0..CLK_DIV-1 every clk and wraps.
  - `pix_en` = (div_cnt == CLK_DIV-1).
  - With CLK_DIV=1, `pix_en` is constantly high after reset.
- Counters change only on a clk edge where `pix_en` is high.
  - hCount increments. At H_TOTAL-1 it wraps to 0 and vCount increments.
  - vCount wraps to 0 at V_TOTAL-1 when hCount also wraps.
  - Counters never exceed TOTAL-1; no other wrap paths exist.
- Derived outputs are registered. They are computed from next-state counters, so they describe exactly the (hCount,vCount) pair visible in the same cycle, with zero skew.
  - hSync = 0 iff hCount < H_SYNC.
  - vSync = 0 iff vCount < V_SYNC.
  - bright = 1 iff H_SYNC+H_BP ≤ hCount < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP ≤ vCount < V_SYNC+V_BP+V_ACTIVE. With defaults: 144..783 and 35..514.
- Strobes are registered:
  - `line_tick` is high for the single clk cycle in which hCount first reads 0.
  - `frame_tick` is high for the single clk cycle in which (hCount,vCount) first reads (0,0). `line_tick` is also high in that cycle.
- There is no state machine beyond the divider and the two counters. No inputs other than clk/rst exist.

## Timing
- Reset values (async, immediate):
  - div_cnt=0, hCount=0, vCount=0.
  - hSync=0, vSync=0 (counter 0 lies inside the sync pulse).
  - bright=0, line_tick=0, frame_tick=0.
  - pix_en=0 (or 1 when CLK_DIV=1).
- After reset release, the first `pix_en` occurs in clk cycle CLK_DIV-1. hCount reads 1 after CLK_DIV rising edges.
- Each counter value is held for exactly CLK_DIV clks.
  - Line period: H_TOTAL·CLK_DIV = 3200 clk.
  - Frame period: 1,680,000 clk.
  - frame_tick period: 1,680,000 clk, i.e. 59.52 Hz.
- Reset asserted mid-frame: all state returns to reset values immediately. No tick is emitted on release. Counting restarts as from power-up.
- Strobes never assert in reset or in the first CLK_DIV·H_TOTAL clks after release. The exception is line_tick at the first line wrap.

## Test plan
- Reset then release: all outputs at reset values, with hSync=vSync=0. pix_en is high in cycles 3, 7, 11, … and hCount=1 after edge 4.
- Line wrap: at hCount=799, the next pix_en edge gives hCount=0, vCount+1, line_tick=1 for exactly 1 clk. hSync is 0 for hCount 0..95 and rises at 96.
- Frame wrap: from (799,524), the next pix_en edge gives (0,0) with frame_tick=line_tick=1 for 1 clk. Consecutive frame_ticks are 1,680,000 clk apart. vSync is low only for vCount 0..1.
- Bright window: bright=0 at hCount 143, 1 at 144 and 783, 0 at 784 (vCount=35). bright=0 at vCount 34 and 515, 1 at 35 and 514 (hCount=200). Same-cycle alignment with the counters is required.
- Mid-frame reset: rst pulse of 1 clk at (400,300). Outputs reach reset values asynchronously, then re-run the power-up sequence. No spurious frame_tick occurs.
- CLK_DIV=1 build: pix_en constantly high, line period 800 clk, frame period 420,000 clk, window edges unchanged.
